// File: rtl/cache_mem_arbiter.sv
// Two-master arbiter between the I-cache and D-cache memory ports and one shared pipelined memory.
// Locks the grant for a fill and tags each read so returning words reach the cache that issued them.
module cache_mem_arbiter #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        d_MemRead,
    input  logic        d_MemWrite,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_rdata,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic [15:0] rdata,
    output logic        i_wait,
    output logic        d_wait
);

    // state    | meaning
    // OWN_NONE | no master held the grant last cycle
    // OWN_I    | I-cache held the grant last cycle; keeps it while requesting
    // OWN_D    | D-cache held the grant last cycle; keeps it while requesting
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } own_t;

    own_t state_q, state_d;
    logic last_is_d_q;
    logic i_req, d_req;
    logic grant_i, grant_d;
    logic [MEM_LATENCY-1:0] tag_valid_q;
    logic [MEM_LATENCY-1:0] tag_owner_d_q;

    assign i_req = i_MemRead | i_MemWrite;
    assign d_req = d_MemRead | d_MemWrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= OWN_NONE;
            last_is_d_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (grant_i) begin
                last_is_d_q <= 1'b0;
            end else if (grant_d) begin
                last_is_d_q <= 1'b1;
            end
        end
    end

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        state_d = OWN_NONE;
        if (state_q == OWN_I && i_req) begin
            grant_i = 1'b1;
        end else if (state_q == OWN_D && d_req) begin
            grant_d = 1'b1;
        end else if (i_req && !d_req) begin
            grant_i = 1'b1;
        end else if (d_req && !i_req) begin
            grant_d = 1'b1;
        end else if (i_req && d_req) begin
            // contention without a lock: alternate away from the last owner
            grant_i = last_is_d_q;
            grant_d = ~last_is_d_q;
        end
        if (grant_i) begin
            state_d = OWN_I;
        end else if (grant_d) begin
            state_d = OWN_D;
        end
    end

    always_comb begin
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;
        if (grant_i) begin
            mem_MemRead  = i_MemRead;
            mem_MemWrite = i_MemWrite;
            mem_addr     = i_addr;
            mem_wdata    = i_wdata;
        end else if (grant_d) begin
            mem_MemRead  = d_MemRead;
            mem_MemWrite = d_MemWrite;
            mem_addr     = d_addr;
            mem_wdata    = d_wdata;
        end
    end

    assign i_wait = i_req & ~grant_i;
    assign d_wait = d_req & ~grant_d;

    // one tag per memory pipeline slot; writes and idle cycles enter as invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid_q   <= '0;
            tag_owner_d_q <= '0;
        end else begin
            tag_valid_q[0]   <= mem_MemRead;
            tag_owner_d_q[0] <= grant_d;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                tag_valid_q[k]   <= tag_valid_q[k-1];
                tag_owner_d_q[k] <= tag_owner_d_q[k-1];
            end
        end
    end

    assign i_data_valid = mem_data_valid & tag_valid_q[MEM_LATENCY-1] & ~tag_owner_d_q[MEM_LATENCY-1];
    assign d_data_valid = mem_data_valid & tag_valid_q[MEM_LATENCY-1] &  tag_owner_d_q[MEM_LATENCY-1];
    assign rdata        = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios then random traffic, all checked each cycle
// against a rule-level model of grant ownership and a per-cycle log of who issued each read.
module tb_cache_mem_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_MemRead, i_MemWrite, d_MemRead, d_MemWrite;
    logic [15:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        mem_MemRead, mem_MemWrite;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_data_valid;
    logic [15:0] mem_rdata;
    logic        i_data_valid, d_data_valid;
    logic [15:0] rdata;
    logic        i_wait, d_wait;

    cache_mem_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_addr(i_addr), .i_wdata(i_wdata),
        .d_MemRead(d_MemRead), .d_MemWrite(d_MemWrite), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid), .rdata(rdata),
        .i_wait(i_wait), .d_wait(d_wait)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    // 0 = nobody, 1 = I-cache, 2 = D-cache
    int owner_hist [0:4095];
    bit mem_issue  [0:4095];
    int m_lock = 0;
    int m_last = 2;
    bit spur_en = 1'b0;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_i(input logic r, input logic w, input logic [15:0] a, input logic [15:0] wd);
        i_MemRead = r; i_MemWrite = w; i_addr = a; i_wdata = wd;
    endtask

    task automatic set_d(input logic r, input logic w, input logic [15:0] a, input logic [15:0] wd);
        d_MemRead = r; d_MemWrite = w; d_addr = a; d_wdata = wd;
    endtask

    // One clock cycle: predict, drive memory side, check at negedge, advance model at posedge.
    task automatic step();
        bit ireq, dreq, in_rst, ret;
        int lk, ls, g, own_ret, lo;
        logic [33:0] exp_mem;
        ireq   = i_MemRead | i_MemWrite;
        dreq   = d_MemRead | d_MemWrite;
        in_rst = (rst !== 1'b1);
        lk = in_rst ? 0 : m_lock;
        ls = in_rst ? 2 : m_last;
        if (lk == 1 && ireq)       g = 1;
        else if (lk == 2 && dreq)  g = 2;
        else if (ireq && !dreq)    g = 1;
        else if (dreq && !ireq)    g = 2;
        else if (ireq && dreq)     g = (ls == 2) ? 1 : 2;
        else                       g = 0;
        if (g == 1)      exp_mem = {i_MemRead, i_MemWrite, i_addr, i_wdata};
        else if (g == 2) exp_mem = {d_MemRead, d_MemWrite, d_addr, d_wdata};
        else             exp_mem = '0;

        mem_issue[cyc]  = exp_mem[33];
        owner_hist[cyc] = (exp_mem[33] && !in_rst) ? g : 0;
        if (in_rst) begin
            lo = (cyc >= L) ? cyc - L : 0;
            for (int k = lo; k <= cyc; k++) owner_hist[k] = 0;
        end
        // memory keeps answering reads it saw, regardless of arbiter reset
        ret = (cyc >= L) && mem_issue[cyc-L];
        if (!ret && spur_en && $urandom_range(0, 3) == 0) ret = 1'b1;
        own_ret = (cyc >= L) ? owner_hist[cyc-L] : 0;
        mem_data_valid = ret;
        mem_rdata      = ret ? 16'($urandom) : 16'h0000;

        @(negedge clk);
        chk("mem_bus", {mem_MemRead, mem_MemWrite, mem_addr, mem_wdata}, exp_mem);
        chk("i_data_valid", i_data_valid, ret && own_ret == 1);
        chk("d_data_valid", d_data_valid, ret && own_ret == 2);
        chk("i_wait", i_wait, ireq && g != 1);
        chk("d_wait", d_wait, dreq && g != 2);
        chk("rdata", rdata, mem_rdata);

        @(posedge clk);
        if (in_rst) begin
            m_lock = 0;
            m_last = 2;
        end else begin
            m_lock = g;
            if (g != 0) m_last = g;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_n(input int n);
        set_i(0, 0, 16'h0, 16'h0);
        set_d(0, 0, 16'h0, 16'h0);
        repeat (n) step();
    endtask

    task automatic reset_n(input int n);
        rst = 1'b0;
        idle_n(n);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        set_i(0, 0, 16'h0, 16'h0);
        set_d(0, 0, 16'h0, 16'h0);
        mem_data_valid = 1'b0;
        mem_rdata = 16'h0;
        #1;
        reset_n(2);

        // I-cache fill of 8 sequential words
        for (int k = 0; k < 8; k++) begin
            set_i(1, 0, 16'(16'h0040 + 2 * k), 16'h0);
            step();
        end
        idle_n(L + 2);

        // simultaneous requests from reset: I wins, D waits until I releases
        reset_n(1);
        set_d(1, 0, 16'hA000, 16'h0);
        for (int k = 0; k < 4; k++) begin
            set_i(1, 0, 16'(16'h0100 + 2 * k), 16'h0);
            step();
        end
        set_i(0, 0, 16'h0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            set_d(1, 0, 16'(16'hA000 + 2 * k), 16'h0);
            step();
        end
        idle_n(L + 2);

        // D-cache fill with the I-cache arriving mid-fill
        for (int k = 0; k < 8; k++) begin
            set_d(1, 0, 16'(16'h2000 + 2 * k), 16'h0);
            if (k >= 2) set_i(1, 0, 16'h0300, 16'h0);
            step();
        end
        set_d(0, 0, 16'h0, 16'h0);
        repeat (2) step();
        idle_n(L + 2);

        // single write-through from the D-cache
        set_d(0, 1, 16'h1234, 16'hBEEF);
        step();
        idle_n(L + 2);

        // in-flight I reads return to I after the grant moves to D
        for (int k = 0; k < 3; k++) begin
            set_i(1, 0, 16'(16'h0500 + 2 * k), 16'h0);
            step();
        end
        set_i(0, 0, 16'h0, 16'h0);
        set_d(1, 0, 16'h6000, 16'h0);
        step();
        idle_n(L + 2);

        // reset while a read is in flight: its late return is discarded
        set_i(1, 0, 16'h0700, 16'h0);
        step();
        idle_n(1);
        reset_n(1);
        idle_n(L + 2);

        // random traffic with stray memory valid pulses and occasional resets
        spur_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) >= 7) i_MemRead = ~i_MemRead;
            if ($urandom_range(0, 9) >= 7) d_MemRead = ~d_MemRead;
            i_MemWrite = ($urandom_range(0, 15) == 0);
            d_MemWrite = ($urandom_range(0, 5) == 0);
            i_addr  = 16'($urandom);
            i_wdata = 16'($urandom);
            d_addr  = 16'($urandom);
            d_wdata = 16'($urandom);
            rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst = 1'b1;
        spur_en = 1'b0;
        idle_n(L + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-master arbiter between the I-cache and D-cache memory-control ports and the single shared 4-cycle pipelined main memory. Each cycle it forwards one cache's read/write request to memory. It locks the grant to that cache for the duration of a block fill. It routes each returning read word and its valid strobe back to the cache that issued the read. The cache that is not granted sees a wait signal, which the pipeline ORs into its stall.

## Interface
- MEM_LATENCY, 4, cycles from a read issued to memory until its data_valid (≥1)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- i_MemRead  input  1  I-cache read request (held high for a whole fill)
- i_MemWrite  input  1  I-cache write request (tie 0; honoured if driven)
- i_addr  input  16  I-cache memory address
- i_wdata  input  16  I-cache write data
- d_MemRead  input  1  D-cache read request
- d_MemWrite  input  1  D-cache write request (single-cycle, write-through)
- d_addr  input  16  D-cache memory address
- d_wdata  input  16  D-cache write data
- mem_MemRead  output  1  read enable to memory
- mem_MemWrite  output  1  write enable to memory
- mem_addr  output  16  address to memory
- mem_wdata  output  16  write data to memory
- mem_data_valid  input  1  memory read data valid
- mem_rdata  input  16  memory read data
- i_data_valid  output  1  returned word belongs to I-cache
- d_data_valid  output  1  returned word belongs to D-cache
- rdata  output  16  mem_rdata passed through unregistered to both caches
- i_wait  output  1  I-cache requesting but not granted
- d_wait  output  1  D-cache requesting but not granted

## Operation
- Request: i_req = i_MemRead|i_MemWrite; d_req = d_MemRead|d_MemWrite.
- State register: OWN_NONE, OWN_I, OWN_D. Separate register last_owner (I/D) is set to D at reset.
- Current-cycle grant is combinational:
  - OWN_I and i_req → I; OWN_D and d_req → D (lock).
  - Otherwise, if exactly one master requests, that master wins.
  - Otherwise, if both request, the master ≠ last_owner wins (alternation). With last_owner=D after reset, I wins the first contention, then D the next, etc.
  - Otherwise no grant.
- Next state = OWN_<granted> when a grant is made, else OWN_NONE. last_owner updates to the granted master whenever a grant is made.
- Memory outputs take the granted master's MemRead/MemWrite/addr/wdata in the same cycle. With no grant, mem_MemRead=mem_MemWrite=0, mem_addr=0, mem_wdata=0.
- If the granted master asserts both MemRead and MemWrite, both are forwarded; memory-side priority is outside this block.
- i_wait = i_req & grant≠I; d_wait = d_req & grant≠D (combinational).
- Owner tag pipeline: MEM_LATENCY stages of 2-bit {valid, owner}. Each cycle stage 0 loads {mem_MemRead, grant}; a write or an idle cycle loads valid=0.
- Return routing: when mem_data_valid=1 and the last stage is valid, raise i_data_valid or d_data_valid per the stage's owner.
  - mem_data_valid with an invalid last stage is dropped: both valids stay 0.
- A lock change never corrupts routing: words still in flight for the old owner return to it after the grant has moved.

## Timing
- Grant-to-memory latency 0 cycles: a request in an idle cycle reaches memory the same cycle.
- Read issued at cycle t returns routed valid at t+MEM_LATENCY, same cycle as mem_data_valid, with no added latency.
- Reset (rst=0, any time): state=OWN_NONE, last_owner=D, all tag stages invalid. All outputs are combinational from these and the inputs: with no requests, every output is 0.
  - Reads in flight at reset are discarded; their later mem_data_valid pulses raise no cache valid.
- Lock release: when the owner drops its request in cycle t, the other waiting master is granted in cycle t with no bubble, and its wait drops in t.
- A continuous fill from one master starves the other for the fill length: 8 reads plus MEM_LATENCY drain on the cache side. This is acceptable by design.

## Test plan
- After reset, i_MemRead=1, i_addr=0x0040, held for 8 cycles with addr +2 each cycle → mem_addr follows 0x0040..0x004E in the same cycles; i_data_valid pulses at cycles 4..11 with mem_rdata; d_data_valid stays 0.
- i_req and d_req both rise in the same cycle from reset → I granted (last_owner=D); d_wait=1 until i_MemRead drops at cycle t; d_addr appears on mem_addr at cycle t.
- D-cache fill in progress (owner D); I-cache requests mid-fill → i_wait=1 for the whole fill; no I address reaches memory; last D word returns with d_data_valid, never i_data_valid.
- d_MemWrite=1 for 1 cycle, d_addr=0x1234, d_wdata=0xBEEF, while idle → mem_MemWrite=1, mem_addr=0x1234, mem_wdata=0xBEEF that cycle; no data_valid 4 cycles later.
- I fill issues 3 reads, then i_MemRead drops and D issues 1 read the next cycle → the 3 returns raise i_data_valid, the 4th raises d_data_valid.
- rst=0 for 1 cycle, 2 cycles after a read issue, with memory still asserting mem_data_valid 2 cycles later → i_data_valid=d_data_valid=0; all outputs 0 during reset.
